// File: rtl/dram_pkg.sv
// dram_pkg -- shared types and default timing for the dram_model slice.
//   dram_cmd_e   : decoded command (NOP, ACT, PRE, RD, WR)
//   bank_state_e : bank state (IDLE = no open row, ACTIVE = row latched)
//   DEF_*        : default geometry and timing, in CK cycles
//   decode_cmd() : pin-level command decode shared by the model
package dram_pkg;

  localparam int unsigned DEF_ROW_BITS = 11;
  localparam int unsigned DEF_COL_BITS = 10;
  localparam int unsigned DEF_T_RP     = 5;
  localparam int unsigned DEF_T_RCD    = 5;
  localparam int unsigned DEF_T_CL     = 5;

  typedef enum logic [2:0] {NOP, ACT, PRE, RD, WR} dram_cmd_e;
  typedef enum logic {IDLE, ACTIVE} bank_state_e;

  // Any encoding not listed decodes to NOP (including RAS/CAS both low).
  function automatic dram_cmd_e decode_cmd(input logic csn, input logic rasn,
                                           input logic casn, input logic [3:0] wen);
    dram_cmd_e c;
    c = NOP;
    if (!csn) begin
      if (!rasn && casn) begin
        if (wen == 4'hF)      c = ACT;
        else if (wen == 4'h0) c = PRE;
      end else if (rasn && !casn) begin
        c = (wen == 4'hF) ? RD : WR;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/dram_rd_pipe.sv
// dram_rd_pipe -- fixed-latency read return pipeline, T_CL stages of
// valid+data. The last stage is the output register: its data only loads on
// a valid word so the output holds the last returned value.
//   ck, rst           : clock, synchronous active-high flush
//   in_valid, in_data : word entering stage 0
//   out_valid         : one-cycle pulse when a word leaves the last stage
//   out_data          : last returned word (0 after reset)
module dram_rd_pipe
  import dram_pkg::*;
#(
  parameter int unsigned T_CL = DEF_T_CL,
  parameter int unsigned W    = 32
) (
  input  logic         ck,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [T_CL-1:0] vld;
  logic [W-1:0]    dat   [T_CL];
  logic [T_CL-1:0] src_v;
  logic [W-1:0]    src_d [T_CL];

  // Source of each stage: the pipe input for stage 0, else the previous stage.
  always_comb begin
    src_v = '0;
    for (int unsigned k = 0; k < T_CL; k++) src_d[k] = '0;
    src_v[0] = in_valid;
    src_d[0] = in_data;
    for (int unsigned k = 1; k < T_CL; k++) begin
      src_v[k] = vld[k-1];
      src_d[k] = dat[k-1];
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      vld          <= '0;
      dat[T_CL-1]  <= '0;
    end else begin
      vld <= src_v;
      for (int unsigned k = 0; k + 1 < T_CL; k++) dat[k] <= src_d[k];
      if (src_v[T_CL-1]) dat[T_CL-1] <= src_d[T_CL-1];
    end
  end

  assign out_valid = vld[T_CL-1];
  assign out_data  = dat[T_CL-1];

endmodule

// File: rtl/dram_model.sv
// dram_model -- single-bank SDRAM-style behavioural memory, 32-bit words with
// per-byte write enables, T_CL read latency.
//   CK    : clock, rising edge        RST  : synchronous active-high reset
//   CSn   : chip select (1 = NOP)     RASn/CASn : row/column strobes
//   WEn   : per-byte write enable     A    : row (ACT) / column A[9:0] (RD/WR)
//   D     : write data                Q    : last returned read word
//   VALID : one-cycle pulse when Q carries new read data
// Optional macro DRAM_TIMING_CHECK_EN: drop and $error-report commands that
// break bank-state or tRP/tRCD rules. Without it every decoded command runs.
module dram_model
  import dram_pkg::*;
#(
  parameter int unsigned ROW_BITS = DEF_ROW_BITS,
  parameter int unsigned COL_BITS = DEF_COL_BITS,
  parameter int unsigned T_RP     = DEF_T_RP,
  parameter int unsigned T_RCD    = DEF_T_RCD,
  parameter int unsigned T_CL     = DEF_T_CL
) (
  input  logic                CK,
  input  logic                RST,
  input  logic                CSn,
  input  logic                RASn,
  input  logic                CASn,
  input  logic [3:0]          WEn,
  input  logic [ROW_BITS-1:0] A,
  input  logic [31:0]         D,
  output logic [31:0]         Q,
  output logic                VALID
);

  localparam int unsigned AW    = ROW_BITS + COL_BITS;
  localparam int unsigned DEPTH = 1 << AW;

  // Byte planes indexed by word address {row, col}; never reset.
  logic [7:0] Memory_byte0 [DEPTH];
  logic [7:0] Memory_byte1 [DEPTH];
  logic [7:0] Memory_byte2 [DEPTH];
  logic [7:0] Memory_byte3 [DEPTH];

  bank_state_e         state, state_next;
  logic [ROW_BITS-1:0] row;
  dram_cmd_e           cmd_raw, cmd_exec;
  logic [AW-1:0]       word_addr;
  logic [31:0]         rd_word;
  logic                cap_valid;
  logic [31:0]         cap_data;

  // Commands are ignored while reset is asserted.
  assign cmd_raw   = RST ? NOP : decode_cmd(CSn, RASn, CASn, WEn);
  assign word_addr = {row, A[COL_BITS-1:0]};
  assign rd_word   = {Memory_byte3[word_addr], Memory_byte2[word_addr],
                      Memory_byte1[word_addr], Memory_byte0[word_addr]};

`ifdef DRAM_TIMING_CHECK_EN
  logic [7:0]  rp_cnt, rcd_cnt;
  logic [31:0] cyc_cnt;
  logic        cmd_legal;

  // Counters load T-1 on the command and count down; zero means satisfied.
  always_comb begin
    cmd_legal = 1'b1;
    case (cmd_raw)
      ACT:     cmd_legal = (state == IDLE)   && (rp_cnt == '0);
      RD, WR:  cmd_legal = (state == ACTIVE) && (rcd_cnt == '0);
      default: cmd_legal = 1'b1;
    endcase
  end

  assign cmd_exec = cmd_legal ? cmd_raw : NOP;

  always_ff @(posedge CK) begin
    if (RST) begin
      rp_cnt  <= '0;
      rcd_cnt <= '0;
      cyc_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (cmd_exec == PRE && state == ACTIVE) rp_cnt <= 8'(T_RP - 1);
      else if (rp_cnt != '0)                  rp_cnt <= rp_cnt - 8'd1;
      if (cmd_exec == ACT)                    rcd_cnt <= 8'(T_RCD - 1);
      else if (rcd_cnt != '0)                 rcd_cnt <= rcd_cnt - 8'd1;
      if (!cmd_legal)
        $error("dram_model: cycle %0d: %s dropped (bank %s)",
               cyc_cnt, cmd_raw.name(), state.name());
    end
  end
`else
  assign cmd_exec = cmd_raw;
`endif

  // Bank state machine
  always_comb begin
    state_next = state;
    case (cmd_exec)
      ACT:     state_next = ACTIVE;
      PRE:     state_next = IDLE;
      default: state_next = state;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge CK) begin
    if (RST)                  row <= '0;
    else if (cmd_exec == ACT) row <= A;
  end

  always_ff @(posedge CK) begin
    if (cmd_exec == WR) begin
      if (!WEn[0]) Memory_byte0[word_addr] <= D[7:0];
      if (!WEn[1]) Memory_byte1[word_addr] <= D[15:8];
      if (!WEn[2]) Memory_byte2[word_addr] <= D[23:16];
      if (!WEn[3]) Memory_byte3[word_addr] <= D[31:24];
    end
  end

  // Read data is captured at the command edge, so later writes to the same
  // word cannot disturb it; the pipe adds the remaining T_CL edges.
  always_ff @(posedge CK) begin
    if (RST) cap_valid <= 1'b0;
    else     cap_valid <= (cmd_exec == RD);
    if (cmd_exec == RD) cap_data <= rd_word;
  end

  dram_rd_pipe #(
    .T_CL (T_CL),
    .W    (32)
  ) u_rd_pipe (
    .ck        (CK),
    .rst       (RST),
    .in_valid  (cap_valid),
    .in_data   (cap_data),
    .out_valid (VALID),
    .out_data  (Q)
  );

endmodule

// File: tb/tb_dram_model.sv
module tb_dram_model;
  import dram_pkg::*;

  localparam int unsigned TCL  = 5;
  localparam int unsigned TRCD = 5;
  localparam int unsigned TRP  = 5;

  logic        CK = 1'b0;
  logic        RST, CSn, RASn, CASn;
  logic [3:0]  WEn;
  logic [10:0] A;
  logic [31:0] D;
  logic [31:0] Q;
  logic        VALID;

  dram_model #(
    .ROW_BITS (11),
    .COL_BITS (10),
    .T_RP     (TRP),
    .T_RCD    (TRCD),
    .T_CL     (TCL)
  ) dut (
    .CK    (CK),
    .RST   (RST),
    .CSn   (CSn),
    .RASn  (RASn),
    .CASn  (CASn),
    .WEn   (WEn),
    .A     (A),
    .D     (D),
    .Q     (Q),
    .VALID (VALID)
  );

  always #5 CK = ~CK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: word store, list of in-flight returns, bank bookkeeping.
  typedef struct {
    int          due;
    logic [31:0] data;
  } ret_t;

  logic [31:0] m_mem [int];
  ret_t        m_ret [$];
  logic [31:0] m_last_q = '0;
  int          m_row    = 0;
  bit          m_active = 0;
  int          m_act_e  = -1000;
  int          m_pre_e  = -1000;
  int          e_now    = 0;

  function automatic dram_cmd_e bdecode(logic csn, logic rasn, logic casn, logic [3:0] wen);
    if (csn) return NOP;
    case ({rasn, casn})
      2'b01:   return (wen == 4'hF) ? ACT : ((wen == 4'h0) ? PRE : NOP);
      2'b10:   return (wen == 4'hF) ? RD : WR;
      default: return NOP;
    endcase
  endfunction

  function automatic int key_of(int row, int col);
    return row * 1024 + (col % 1024);
  endfunction

  task automatic tick_raw(input logic csn, input logic rasn, input logic casn,
                          input logic [3:0] wen, input int addr, input logic [31:0] data,
                          input bit rst);
    dram_cmd_e   c;
    int          k;
    logic [31:0] w;
    logic        exp_v;
    RST = rst; CSn = csn; RASn = rasn; CASn = casn; WEn = wen;
    A = 11'(addr); D = data;
    @(posedge CK);
    #1;
    e_now++;
    if (rst) begin
      m_ret.delete();
      m_last_q = '0;
      m_active = 0;
      m_act_e  = -1000;
      m_pre_e  = -1000;
    end else begin
      c = bdecode(csn, rasn, casn, wen);
`ifdef DRAM_TIMING_CHECK_EN
      if (c == ACT && (m_active || e_now - m_pre_e < int'(TRP))) c = NOP;
      if ((c == RD || c == WR) && (!m_active || e_now - m_act_e < int'(TRCD))) c = NOP;
`endif
      k = key_of(m_row, addr);
      case (c)
        ACT: begin m_row = addr; m_active = 1; m_act_e = e_now; end
        PRE: if (m_active) begin m_active = 0; m_pre_e = e_now; end
        RD:  m_ret.push_back('{due: e_now + int'(TCL), data: m_mem.exists(k) ? m_mem[k] : 'x});
        WR: begin
          w = m_mem.exists(k) ? m_mem[k] : 'x;
          for (int b = 0; b < 4; b++)
            if (!wen[b]) w[8*b +: 8] = data[8*b +: 8];
          m_mem[k] = w;
        end
        default: ;
      endcase
    end
    exp_v = 1'b0;
    if (m_ret.size() > 0 && m_ret[0].due == e_now) begin
      exp_v    = 1'b1;
      m_last_q = m_ret[0].data;
      void'(m_ret.pop_front());
    end
    check($sformatf("valid@%0d", e_now), {31'd0, VALID}, {31'd0, exp_v});
    check($sformatf("q@%0d", e_now), Q, m_last_q);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) tick_raw(1, 1, 1, 4'hF, 0, '0, 0);
  endtask
  task automatic act(input int row);                  tick_raw(0, 0, 1, 4'hF, row, '0, 0); endtask
  task automatic pre();                               tick_raw(0, 0, 1, 4'h0, 0, '0, 0);   endtask
  task automatic rd(input int col);                   tick_raw(0, 1, 0, 4'hF, col, '0, 0); endtask
  task automatic wr(input int col, input logic [31:0] d, input logic [3:0] wen);
    tick_raw(0, 1, 0, wen, col, d, 0);
  endtask
  task automatic rst_cycle();                         tick_raw(1, 1, 1, 4'hF, 0, '0, 1);   endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          rows [4];
    int          r, col, k;
    logic [3:0]  wen;
    logic [31:0] rb;
    rows = '{11'h100, 11'h00F, 11'h7FF, 11'h2AA};
    RST = 1; CSn = 1; RASn = 1; CASn = 1; WEn = 4'hF; A = '0; D = '0;

    rst_cycle();
    rst_cycle();
    check("reset_valid", {31'd0, VALID}, 32'd0);
    check("reset_q", Q, 32'd0);

    // Basic read, latency exactly TCL
    act(11'h100);
    nop(TRCD - 1);
    wr(11'h004, 32'hDEADBEEF, 4'h0);
    rd(11'h004);
    nop(TCL);
    check("basic_valid", {31'd0, VALID}, 32'd1);
    check("basic_q", Q, 32'hDEADBEEF);
    nop(1);

    // Byte-masked write merge
    wr(11'h010, 32'h12345678, 4'b0000);
    wr(11'h010, 32'hAABBCCDD, 4'b1100);
    rd(11'h010);
    nop(TCL);
    check("mask_q", Q, 32'h1234CCDD);

    // Back-to-back reads
    for (int i = 0; i < 4; i++) wr(i, 32'(i + 1), 4'h0);
    for (int i = 0; i < 4; i++) rd(i);
    nop(TCL - 3);
    check("b2b_q1", Q, 32'd1);
    for (int i = 2; i <= 4; i++) begin
      nop(1);
      check($sformatf("b2b_q%0d", i), Q, 32'(i));
      check($sformatf("b2b_v%0d", i), {31'd0, VALID}, 32'd1);
    end
    nop(1);
    check("b2b_done_valid", {31'd0, VALID}, 32'd0);

    // Write behind a pending read does not disturb it
    rd(11'h010);
    wr(11'h010, 32'h0BADF00D, 4'h0);
    nop(TCL - 1);
    check("rdw_q", Q, 32'h1234CCDD);

    // Address corners of the word space
    pre();
    nop(TRP - 1);
    act(11'h00F);
    nop(TRCD - 1);
    wr(11'h3FF, 32'hFFFFFFFF, 4'h0);
    pre();
    nop(TRP - 1);
    act(11'h100);
    nop(TRCD - 1);
    wr(11'h000, 32'h00012345, 4'h0);
    rb = {dut.Memory_byte3[21'h03FFF], dut.Memory_byte2[21'h03FFF],
          dut.Memory_byte1[21'h03FFF], dut.Memory_byte0[21'h03FFF]};
    check("mem_03fff", rb, 32'hFFFFFFFF);
    rb = {dut.Memory_byte3[21'h40000], dut.Memory_byte2[21'h40000],
          dut.Memory_byte1[21'h40000], dut.Memory_byte0[21'h40000]};
    check("mem_40000", rb, 32'h00012345);

    // Reset with a read in flight
    rd(11'h004);
    nop(1);
    rst_cycle();
    act(11'h100);
    nop(TCL);
    check("rst_flush_q", Q, 32'd0);
    check("rst_flush_valid", {31'd0, VALID}, 32'd0);
    rb = {dut.Memory_byte3[21'h40004], dut.Memory_byte2[21'h40004],
          dut.Memory_byte1[21'h40004], dut.Memory_byte0[21'h40004]};
    check("rst_mem_kept", rb, 32'hDEADBEEF);
    rd(11'h004);
    nop(TCL);
    check("rst_then_read", Q, 32'hDEADBEEF);

    // Randomized legal traffic with decode corner NOPs and occasional reset
    for (int n = 0; n < 700; n++) begin
      r = int'($urandom_range(0, 99));
      if (r == 0) begin
        rst_cycle();
      end else if (!m_active) begin
        if (e_now + 1 - m_pre_e >= int'(TRP)) act(rows[$urandom_range(0, 3)]);
        else nop(1);
      end else if (e_now + 1 - m_act_e < int'(TRCD)) begin
        nop(1);
      end else begin
        col = int'($urandom_range(0, 15));
        k   = key_of(m_row, col);
        if (r < 6) begin
          pre();
        end else if (r < 18) begin
          case ($urandom_range(0, 3))
            0:       tick_raw(0, 0, 0, 4'($urandom), col, $urandom, 0);
            1:       tick_raw(0, 0, 1, 4'h5, col, $urandom, 0);
            2:       tick_raw(0, 1, 1, 4'($urandom), col, $urandom, 0);
            default: tick_raw(1, 0, 0, 4'h0, col, $urandom, 0);
          endcase
        end else if (r < 50 || !m_mem.exists(k)) begin
          wen = m_mem.exists(k) ? 4'($urandom_range(0, 14)) : 4'h0;
          wr(col, $urandom, wen);
        end else begin
          rd(col);
        end
      end
    end
    nop(TCL + 1);

`ifdef DRAM_TIMING_CHECK_EN
    // Illegal commands are dropped
    rst_cycle();
    act(11'h100);
    nop(1);
    rd(11'h004);
    nop(TCL);
    check("early_rd_valid", {31'd0, VALID}, 32'd0);
    pre();
    nop(2);
    act(11'h00F);
    nop(TRCD + 1);
    rd(11'h3FF);
    nop(TCL);
    check("early_act_valid", {31'd0, VALID}, 32'd0);
    check("early_act_q", Q, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_model.md
DRAM_MODEL -- requirements
Module: dram_model

Interface
REQ-001 Parameter ROW_BITS, 11, width of the row address (taken from A[10:0]).
REQ-002 Parameter COL_BITS, 10, width of the column address (taken from A[9:0]).
REQ-003 Parameter T_RP, 5, minimum cycles from PRECHARGE to the next ACTIVATE.
REQ-004 Parameter T_RCD, 5, minimum cycles from ACTIVATE to the first READ or WRITE.
REQ-005 Parameter T_CL, 5, cycles from a READ command edge to the edge where VALID/Q are presented.
REQ-006 CK  input  1  clock; all activity on the rising edge.
REQ-007 RST  input  1  reset; synchronous, active-high.
REQ-008 CSn  input  1  chip select, active-low; CSn=1 is NOP.
REQ-009 RASn  input  1  row strobe, active-low.
REQ-010 CASn  input  1  column strobe, active-low.
REQ-011 WEn  input  4  per-byte write enable, active-low; bit i covers D[8i+7:8i].
REQ-012 A  input  11  multiplexed address: row on ACTIVATE, column A[9:0] on READ/WRITE.
REQ-013 D  input  32  write data.
REQ-014 Q  output  32  read data; holds the last returned word.
REQ-015 VALID  output  1  one-cycle pulse marking Q as new read data.

Function
REQ-016 Storage SHALL be four byte arrays Memory_byte0..Memory_byte3, each with 2^(ROW_BITS+COL_BITS) entries, indexed by word address {row,col}; the arrays are hierarchically visible for $readmemh preload and end-of-test readback.
REQ-017 Command decode at each CK edge with CSn=0: RASn=0,CASn=1,WEn=4'hF -> ACTIVATE; RASn=0,CASn=1,WEn=4'h0 -> PRECHARGE; RASn=1,CASn=0,WEn=4'hF -> READ; RASn=1,CASn=0,WEn!=4'hF -> WRITE; all other encodings -> NOP.
REQ-018 Bank states: IDLE (no open row) and ACTIVE (row latched); ACTIVATE moves IDLE->ACTIVE and latches A as the row; PRECHARGE moves ACTIVE->IDLE; PRECHARGE in IDLE is a NOP.
REQ-019 WRITE SHALL update, at its edge, only the bytes whose WEn bit is 0 at word {row, A[9:0]}.
REQ-020 READ SHALL sample word {row, A[9:0]} at its edge; exactly T_CL cycles later Q takes that word and VALID=1 for one cycle.
REQ-021 Back-to-back READs, one per cycle, SHALL be accepted and returned in order, one per cycle, each T_CL cycles after its command.
REQ-022 A WRITE to an address with a pending READ SHALL NOT affect the read data (read-at-command-edge semantics).
REQ-023 VALID SHALL be 0 in every cycle without a returning read; Q SHALL hold its value between returns.
REQ-024 Legal-command rules: ACTIVATE only in IDLE with >=T_RP cycles since PRECHARGE; READ/WRITE only in ACTIVE with >=T_RCD cycles since ACTIVATE; PRECHARGE in ACTIVE at any time (pending reads still complete).

Reset
REQ-025 With RST=1 at an edge: Q=0, VALID=0, state IDLE, timing counters satisfied (ACTIVATE legal in the first cycle after reset), read pipeline flushed.
REQ-026 Reset SHALL NOT clear the memory arrays; a read pending when reset is asserted SHALL never return.

Configuration
REQ-027 Macro DRAM_TIMING_CHECK_EN: when defined, commands violating REQ-024 SHALL be dropped (no state, memory or pipeline change) and reported with $error including cycle count and command; when undefined, all decoded commands SHALL execute without timing or state checks (READ/WRITE in IDLE use the last latched row).

Structure
REQ-028 Package dram_pkg SHALL hold the command enum (NOP, ACT, PRE, RD, WR), the bank-state enum (IDLE, ACTIVE) and the default timing constants.
REQ-029 The read-latency pipeline SHALL be one sub-module, dram_rd_pipe (depth T_CL, valid+data per stage, synchronous flush on RST).

Verification
REQ-030 Reset, ACTIVATE row 0x100, wait 5, READ col 0x004 of preloaded word 0xDEADBEEF -> VALID=1 with Q=0xDEADBEEF exactly 5 cycles after the READ, VALID=0 in all other cycles.
REQ-031 WRITE 0x12345678 with WEn=4'b0000, then WRITE 0xAABBCCDD with WEn=4'b1100 to the same address, READ -> Q=0x1234CCDD.
REQ-032 Four consecutive READs of cols 0..3 holding 1,2,3,4 -> VALID high for 4 consecutive cycles, Q=1,2,3,4 in order.
REQ-033 With DRAM_TIMING_CHECK_EN: READ 2 cycles after ACTIVATE -> no VALID pulse, $error issued; ACTIVATE 3 cycles after PRECHARGE -> row unchanged, $error issued.
REQ-034 READ issued, RST asserted 2 cycles later -> VALID stays 0, Q=0, memory contents unchanged; a fresh ACTIVATE is accepted one cycle after reset.
REQ-035 Write 0xFFFFFFFF to word address 0x03FFF and 0x12345 to word 0x40000 (row/col split per REQ-016) -> hierarchical byte-array readback equals both values.
